// File: rtl/matrix_mult_pkg.sv
// Shared constants and types for the matrix multiply engine result path.
package matrix_mult_pkg;

    localparam int BATCH_SIZE          = 8;
    localparam int LOG_BATCH_SIZE      = 3;
    localparam int OUTPUT_FEATURES     = 8;
    localparam int LOG_OUTPUT_FEATURES = 3;
    localparam int OUTPUT_WIDTH        = 16;
    localparam int ROW_WIDTH           = OUTPUT_FEATURES * OUTPUT_WIDTH;

    // One full row of C: element o lives at bits [o*OUTPUT_WIDTH +: OUTPUT_WIDTH].
    typedef logic [ROW_WIDTH-1:0] row_t;

    // Single-buffer phase: collecting rows, or streaming them out.
    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

endpackage

// File: rtl/row_element_mux.sv
// Selects one element from a packed row; purely combinational.
module row_element_mux #(
    parameter int OUTPUT_FEATURES = 8,
    parameter int OUTPUT_WIDTH    = 16,
    parameter int SEL_WIDTH       = 3
) (
    input  logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0] row,
    input  logic [SEL_WIDTH-1:0]                    sel,
    output logic [OUTPUT_WIDTH-1:0]                 elem
);

    logic [OUTPUT_WIDTH-1:0] elems [OUTPUT_FEATURES];

    generate
        for (genvar gi = 0; gi < OUTPUT_FEATURES; gi++) begin : g_split
            assign elems[gi] = row[gi*OUTPUT_WIDTH +: OUTPUT_WIDTH];
        end
    endgenerate

    // Compare-based select so a non-power-of-two element count never indexes out of range.
    always_comb begin
        elem = '0;
        for (int i = 0; i < OUTPUT_FEATURES; i++) begin
            if (sel == SEL_WIDTH'(i)) begin
                elem = elems[i];
            end
        end
    end

endmodule

// File: rtl/result_drain.sv
// Captures BATCH_SIZE rows of C, then streams them element-by-element in
// row-major order over valid/ready. Single buffer alternating FILL / DRAIN.
module result_drain
    import matrix_mult_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ROW_WIDTH-1:0]      wrData,
    input  logic [LOG_BATCH_SIZE-1:0] wrAddr,
    input  logic                      wrEn,
    output logic [OUTPUT_WIDTH-1:0]   outData,
    output logic                      outValid,
    input  logic                      outReady,
    output logic                      outLast,
    output logic                      full,
    output logic                      wrDropped
);

    localparam logic [LOG_BATCH_SIZE-1:0]      R_LAST = LOG_BATCH_SIZE'(BATCH_SIZE - 1);
    localparam logic [LOG_OUTPUT_FEATURES-1:0] C_LAST = LOG_OUTPUT_FEATURES'(OUTPUT_FEATURES - 1);

    drain_state_e                   state_q, state_d;
    logic [BATCH_SIZE-1:0]          bitmap_q, bitmap_d;
    logic [LOG_BATCH_SIZE-1:0]      r_q, r_d;
    logic [LOG_OUTPUT_FEATURES-1:0] c_q, c_d;
    logic                           wr_dropped_q, wr_dropped_d;

    row_t                           row_mem [BATCH_SIZE];
    row_t                           cur_row;
    logic [OUTPUT_WIDTH-1:0]        cur_elem;
    logic [BATCH_SIZE-1:0]          wr_onehot;
    logic                           wr_accept;
    logic                           draining;
    logic                           handshake;
    logic                           last_elem;

    assign draining  = (state_q == DRAIN);
    assign wr_accept = (state_q == FILL) && wrEn && (int'(wrAddr) < BATCH_SIZE);
    assign handshake = draining && outReady;
    assign last_elem = draining && (r_q == R_LAST) && (c_q == C_LAST);

    // One-hot of the row being accepted this cycle, merged into the bitmap.
    generate
        for (genvar gi = 0; gi < BATCH_SIZE; gi++) begin : g_onehot
            assign wr_onehot[gi] = wr_accept && (wrAddr == LOG_BATCH_SIZE'(gi));
        end
    endgenerate

    // Row buffer: plain storage, never reset, written only when a row is accepted.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            row_mem[wrAddr] <= wrData;
        end
    end

    assign cur_row = row_mem[r_q];

    row_element_mux #(
        .OUTPUT_FEATURES(OUTPUT_FEATURES),
        .OUTPUT_WIDTH   (OUTPUT_WIDTH),
        .SEL_WIDTH      (LOG_OUTPUT_FEATURES)
    ) u_elem_mux (
        .row (cur_row),
        .sel (c_q),
        .elem(cur_elem)
    );

    // Next-state: fill bitmap tracking, phase change, and row/column counters.
    always_comb begin
        state_d      = state_q;
        bitmap_d     = bitmap_q;
        r_d          = r_q;
        c_d          = c_q;
        wr_dropped_d = wrEn && !wr_accept;

        case (state_q)
            FILL: begin
                bitmap_d = bitmap_q | wr_onehot;
                if (&bitmap_d) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (handshake) begin
                    if (last_elem) begin
                        state_d  = FILL;
                        bitmap_d = '0;
                        r_d      = '0;
                        c_d      = '0;
                    end else if (c_q == C_LAST) begin
                        c_d = '0;
                        r_d = r_q + LOG_BATCH_SIZE'(1);
                    end else begin
                        c_d = c_q + LOG_OUTPUT_FEATURES'(1);
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Control registers; reset aborts any stream in progress and forgets captured rows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FILL;
            bitmap_q     <= '0;
            r_q          <= '0;
            c_q          <= '0;
            wr_dropped_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitmap_q     <= bitmap_d;
            r_q          <= r_d;
            c_q          <= c_d;
            wr_dropped_q <= wr_dropped_d;
        end
    end

    assign outValid  = draining;
    assign full      = draining;
    assign outLast   = last_elem;
    assign outData   = draining ? cur_elem : '0;
    assign wrDropped = wr_dropped_q;

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: fill/drain ordering, overwrite, backpressure,
// writes during drain, mid-drain reset and back-to-back batches.
module tb_result_drain;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] wrData;
    logic [2:0]   wrAddr;
    logic         wrEn;
    logic [15:0]  outData;
    logic         outValid;
    logic         outReady;
    logic         outLast;
    logic         full;
    logic         wrDropped;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] exp_mem [8][8];
    logic [15:0] got [64];

    result_drain dut (
        .clk      (clk),
        .rst      (rst),
        .wrData   (wrData),
        .wrAddr   (wrAddr),
        .wrEn     (wrEn),
        .outData  (outData),
        .outValid (outValid),
        .outReady (outReady),
        .outLast  (outLast),
        .full     (full),
        .wrDropped(wrDropped)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] row_val(input int m, input int o, input int seed);
        return 16'(seed * 256 + m * 16 + o);
    endfunction

    task automatic write_row(input int m, input int seed);
        logic [127:0] d;
        for (int o = 0; o < 8; o++) begin
            d[o*16 +: 16] = row_val(m, o, seed);
            exp_mem[m][o] = row_val(m, o, seed);
        end
        wrEn   = 1'b1;
        wrAddr = 3'(m);
        wrData = d;
        tick();
        wrEn   = 1'b0;
        $display("write row %0d seed %0d full=%0b", m, seed, full);
    endtask

    task automatic write_row_const(input int m, input logic [15:0] v);
        logic [127:0] d;
        for (int o = 0; o < 8; o++) begin
            d[o*16 +: 16] = v;
            exp_mem[m][o] = v;
        end
        wrEn   = 1'b1;
        wrAddr = 3'(m);
        wrData = d;
        tick();
        wrEn   = 1'b0;
        $display("write row %0d const %h full=%0b", m, v, full);
    endtask

    // mode 0: outReady held high; mode 1: outReady pattern 1,0,0,1 repeating.
    task automatic drain(input int mode, input int stop_after, input bit inject);
        int          k       = 0;
        bit          stalled = 0;
        bit          hs;
        bit          injected;
        logic [15:0] held    = '0;
        for (int cyc = 0; cyc < 400 && k < stop_after; cyc++) begin
            outReady = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (stalled) begin
                check("stall_valid", outValid, 1);
                check("stall_hold", outData, held);
            end
            hs       = outValid && outReady;
            injected = inject && hs && (k == 4 || k == 63);
            wrEn     = injected;
            wrAddr   = 3'(k);
            wrData   = '1;
            if (hs) begin
                got[k] = outData;
                $display("elem %0d data %h last %0b", k, outData, outLast);
                check("data", outData, exp_mem[k / 8][k % 8]);
                check("last", outLast, (k == 63));
            end
            stalled = outValid && !outReady;
            held    = outData;
            tick();
            wrEn = 1'b0;
            if (injected) check("wr_dropped", wrDropped, 1);
            if (hs) k++;
        end
        check("drain_count", k, stop_after);
    endtask

    initial begin
        rst      = 1'b0;
        wrEn     = 1'b0;
        wrAddr   = '0;
        wrData   = '0;
        outReady = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_valid", outValid, 0);
        check("rst_last", outLast, 0);
        check("rst_full", full, 0);
        check("rst_dropped", wrDropped, 0);
        check("rst_data", outData, 0);
        rst = 1'b1;
        tick();

        // 1. Basic order
        for (int m = 0; m < 7; m++) write_row(m, 0);
        check("t1_full_early", full, 0);
        write_row(7, 0);
        check("t1_full", full, 1);
        check("t1_valid", outValid, 1);
        check("t1_first", outData, 16'h0000);
        drain(0, 64, 0);
        check("t1_elem8", got[8], 16'h0010);
        check("t1_elem63", got[63], 16'h0077);
        check("t1_valid_after", outValid, 0);
        check("t1_last_after", outLast, 0);
        check("t1_full_after", full, 0);

        // 2. Out-of-order fill with overwrite of row 3
        write_row(7, 1);
        write_row(3, 1);
        write_row(0, 1);
        write_row_const(3, 16'hAAAA);
        write_row(1, 1);
        write_row(2, 1);
        write_row(4, 1);
        write_row(5, 1);
        check("t2_full_early", full, 0);
        write_row(6, 1);
        check("t2_full", full, 1);
        drain(0, 64, 0);
        check("t2_row3_first", got[24], 16'hAAAA);
        check("t2_row3_last", got[31], 16'hAAAA);
        check("t2_row2_last", got[23], 16'h0127);

        // 3. Backpressure
        for (int m = 0; m < 8; m++) write_row(m, 2);
        drain(1, 64, 0);
        check("t3_valid_after", outValid, 0);

        // 4. Writes during drain are dropped; next fill needs all rows
        for (int m = 0; m < 8; m++) write_row(m, 3);
        drain(0, 64, 1);
        check("t4_valid_after", outValid, 0);
        for (int m = 0; m < 7; m++) write_row(m, 4);
        check("t4_refill_early", full, 0);
        write_row(7, 4);
        check("t4_refill_full", full, 1);
        check("t4_first", outData, 16'h0400);

        // 5. Reset mid-drain
        drain(0, 20, 0);
        rst = 1'b0;
        #1;
        check("t5_valid", outValid, 0);
        check("t5_full", full, 0);
        check("t5_last", outLast, 0);
        check("t5_data", outData, 0);
        tick();
        rst = 1'b1;
        tick();
        for (int m = 0; m < 7; m++) write_row(m, 5);
        check("t5_refill_early", full, 0);
        write_row(7, 5);
        check("t5_refill_full", full, 1);
        check("t5_first", outData, 16'h0500);
        drain(0, 64, 0);

        // 6. Back-to-back batch right after outLast
        for (int m = 0; m < 8; m++) write_row(m, 6);
        check("t6_full", full, 1);
        check("t6_first", outData, 16'h0600);
        drain(0, 64, 0);
        check("t6_elem63", got[63], 16'h0677);
        check("t6_valid_after", outValid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
